// File: rtl/matrix_pkg.sv
// Shared layout for the matrix loader and the processor: state encoding, header offsets,
// operand base address and default dimension limit.
package matrix_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StLoad,
        StChk,
        StRun,
        StError
    } state_t;

    localparam int unsigned HDR_ROWS_A      = 0;
    localparam int unsigned HDR_COLS_A      = 1;
    localparam int unsigned HDR_COLS_B      = 2;
    localparam int unsigned A_BASE          = 3;
    localparam int unsigned DEFAULT_MAX_DIM = 16;

    // Bits needed to hold one legal dimension value.
    function automatic int unsigned dim_w(input int unsigned max_dim);
        return $clog2(max_dim + 1);
    endfunction

endpackage

// File: rtl/mat_size_calc.sv
// Captures the three header dimensions, flags legality on the cols_b byte and registers
// the element count rows_a*cols_a + cols_a*cols_b without truncation.
module mat_size_calc
    import matrix_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MAX_DIM = DEFAULT_MAX_DIM,
    parameter int unsigned TOT_W   = 2 * dim_w(MAX_DIM) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_cap_rows_a,
    input  logic              i_cap_cols_a,
    input  logic              i_cap_cols_b,
    output logic              o_legal,
    output logic [TOT_W-1:0]  o_total
);

    localparam int unsigned       DIM_W     = dim_w(MAX_DIM);
    localparam int unsigned       PROD_W    = 2 * DIM_W;
    localparam logic [DATA_W-1:0] MAX_DIM_V = DATA_W'(MAX_DIM);

    logic [DATA_W-1:0] r_rows_a;
    logic [DATA_W-1:0] r_cols_a;
    logic [TOT_W-1:0]  r_total;
    logic [PROD_W-1:0] w_prod_a;
    logic [PROD_W-1:0] w_prod_b;
    logic [TOT_W-1:0]  w_total;

    function automatic logic dim_ok(input logic [DATA_W-1:0] d);
        return (d != '0) && (d <= MAX_DIM_V);
    endfunction

    // cols_b is taken straight from the input so the verdict is ready on the same edge.
    always_comb begin
        o_legal  = dim_ok(r_rows_a) && dim_ok(r_cols_a) && dim_ok(i_data);
        w_prod_a = PROD_W'(r_rows_a[DIM_W-1:0]) * PROD_W'(r_cols_a[DIM_W-1:0]);
        w_prod_b = PROD_W'(r_cols_a[DIM_W-1:0]) * PROD_W'(i_data[DIM_W-1:0]);
        w_total  = TOT_W'(w_prod_a) + TOT_W'(w_prod_b);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rows_a <= '0;
            r_cols_a <= '0;
            r_total  <= '0;
        end else begin
            if (i_cap_rows_a) r_rows_a <= i_data;
            if (i_cap_cols_a) r_cols_a <= i_data;
            if (i_cap_cols_b) r_total  <= w_total;
        end
    end

    assign o_total = r_total;

endmodule

// File: rtl/matrix_loader.sv
// Host byte-stream loader: parses the dimension header, writes header and operands into
// data memory, then starts the processor. Optional checksum byte: MATRIX_LOADER_CHECKSUM_EN.
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned MAX_DIM = DEFAULT_MAX_DIM
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              start_process,
    input  logic              proc_done,
    output logic              busy,
    output logic              err
);

    localparam int unsigned TOT_W = 2 * dim_w(MAX_DIM) + 1;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_armed;
    logic              r_hdr_second;
    logic [TOT_W-1:0]  r_elem_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
`ifdef MATRIX_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
`endif

    logic              w_fire;
    logic              w_we_next;
    logic [ADDR_W-1:0] w_addr_next;
    logic              w_cap_rows_a;
    logic              w_cap_cols_a;
    logic              w_cap_cols_b;
    logic              w_legal;
    logic [TOT_W-1:0]  w_total;
    logic              w_last_elem;

    mat_size_calc #(
        .DATA_W  (DATA_W),
        .MAX_DIM (MAX_DIM),
        .TOT_W   (TOT_W)
    ) u_size_calc (
        .i_clk        (clock),
        .i_rst_n      (reset_n),
        .i_data       (in_data),
        .i_cap_rows_a (w_cap_rows_a),
        .i_cap_cols_a (w_cap_cols_a),
        .i_cap_cols_b (w_cap_cols_b),
        .o_legal      (w_legal),
        .o_total      (w_total)
    );

    // r_armed keeps in_ready low for the first cycle after a reset edge.
    assign in_ready    = r_armed && (r_state inside {StIdle, StHdr, StLoad, StChk});
    assign w_fire      = in_valid && in_ready;
    assign w_last_elem = (r_elem_cnt == (w_total - TOT_W'(1)));

    always_comb begin
        w_state_next = r_state;
        w_we_next    = 1'b0;
        w_addr_next  = r_addr;
        w_cap_rows_a = 1'b0;
        w_cap_cols_a = 1'b0;
        w_cap_cols_b = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_fire) begin
                    w_state_next = StHdr;
                    w_cap_rows_a = 1'b1;
                    w_we_next    = 1'b1;
                    w_addr_next  = ADDR_W'(HDR_ROWS_A);
                end
            end
            StHdr: begin
                if (w_fire) begin
                    w_we_next = 1'b1;
                    if (!r_hdr_second) begin
                        w_cap_cols_a = 1'b1;
                        w_addr_next  = ADDR_W'(HDR_COLS_A);
                    end else begin
                        w_cap_cols_b = 1'b1;
                        w_addr_next  = ADDR_W'(HDR_COLS_B);
                        w_state_next = w_legal ? StLoad : StError;
                    end
                end
            end
            StLoad: begin
                if (w_fire) begin
                    w_we_next   = 1'b1;
                    w_addr_next = ADDR_W'(A_BASE) + ADDR_W'(r_elem_cnt);
                    if (w_last_elem) begin
`ifdef MATRIX_LOADER_CHECKSUM_EN
                        w_state_next = StChk;
`else
                        w_state_next = StRun;
`endif
                    end
                end
            end
`ifdef MATRIX_LOADER_CHECKSUM_EN
            StChk: begin
                if (w_fire) begin
                    w_state_next = (in_data == r_sum) ? StRun : StError;
                end
            end
`endif
            StRun: begin
                if (proc_done) w_state_next = StIdle;
            end
            StError: begin
                w_state_next = StError;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_armed      <= 1'b0;
            r_hdr_second <= 1'b0;
            r_elem_cnt   <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state <= w_state_next;
            r_armed <= 1'b1;
            r_we    <= w_we_next;
            r_addr  <= w_addr_next;
            if (w_we_next) r_wdata <= in_data;
            if (w_cap_rows_a) r_hdr_second <= 1'b0;
            else if (w_cap_cols_a) r_hdr_second <= 1'b1;
            if (w_cap_cols_b) r_elem_cnt <= '0;
            else if ((r_state == StLoad) && w_fire) r_elem_cnt <= r_elem_cnt + TOT_W'(1);
        end
    end

`ifdef MATRIX_LOADER_CHECKSUM_EN
    // Running sum of every byte that gets written: header plus elements.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sum <= '0;
        end else if (w_cap_rows_a) begin
            r_sum <= in_data;
        end else if (w_we_next) begin
            r_sum <= r_sum + in_data;
        end
    end
`endif

    assign dm_we         = r_we;
    assign dm_addr       = r_addr;
    assign dm_wdata      = r_wdata;
    assign start_process = (r_state == StRun);
    assign busy          = (r_state != StIdle);
    assign err           = (r_state == StError);

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: job-level reference model checked every cycle,
// a table of dimension vectors, hand-written corner sequences and random jobs.
`timescale 1ns/1ps
module tb_matrix_loader;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned MAX_DIM = 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              start_process;
    logic              proc_done;
    logic              busy;
    logic              err;

    always #5 clock = ~clock;

    matrix_loader #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .MAX_DIM (MAX_DIM)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .start_process (start_process),
        .proc_done     (proc_done),
        .busy          (busy),
        .err           (err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;

    // Job-level reference model: bytes accepted so far, dims, running sum, outcome.
    bit         m_armed = 1'b0;
    int         m_cnt   = 0;
    int         m_total = 0;
    bit         m_run   = 1'b0;
    bit         m_err   = 1'b0;
    int         m_hdr[3];
    logic [7:0] m_sum   = '0;
    bit         exp_we;
    int         exp_addr;
    logic [7:0] exp_data;

    typedef struct {
        int r;
        int ca;
        int cb;
        int mode;
        bit legal;
        int total;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_total = 0;
        m_run   = 1'b0;
        m_err   = 1'b0;
        m_sum   = '0;
    endtask

    task automatic model_accept(input logic [7:0] b);
        if (m_cnt < 3) begin
            m_hdr[m_cnt] = int'(b);
            exp_we   = 1'b1;
            exp_addr = m_cnt;
            exp_data = b;
            m_sum    = m_sum + b;
            m_cnt++;
            if (m_cnt == 3) begin
                if (m_hdr[0] == 0 || m_hdr[0] > MAX_DIM || m_hdr[1] == 0 || m_hdr[1] > MAX_DIM ||
                    m_hdr[2] == 0 || m_hdr[2] > MAX_DIM)
                    m_err = 1'b1;
                else
                    m_total = m_hdr[0] * m_hdr[1] + m_hdr[1] * m_hdr[2];
            end
        end else if (m_cnt < 3 + m_total) begin
            exp_we   = 1'b1;
            exp_addr = m_cnt;
            exp_data = b;
            m_sum    = m_sum + b;
            m_cnt++;
`ifndef MATRIX_LOADER_CHECKSUM_EN
            if (m_cnt == 3 + m_total) m_run = 1'b1;
`endif
        end else begin
            m_cnt++;
            if (b == m_sum) m_run = 1'b1;
            else m_err = 1'b1;
        end
    endtask

    // One clock: advance the model on the edge, then compare all outputs 1 ns later.
    task automatic tick(output bit fired);
        bit fire;
        bit done_s;
        bit rst_s;
        fire   = in_valid && m_armed && !m_run && !m_err;
        done_s = proc_done;
        rst_s  = reset_n;
        @(posedge clock);
        exp_we = 1'b0;
        if (!rst_s) begin
            model_reset();
            m_armed = 1'b0;
            fire    = 1'b0;
        end else begin
            m_armed = 1'b1;
            if (fire) model_accept(in_data);
            else if (m_run && done_s) model_reset();
        end
        fired = fire;
        #1;
        check("in_ready", in_ready, m_armed && !m_run && !m_err);
        check("start_process", start_process, m_run);
        check("err", err, m_err);
        check("busy", busy, (m_cnt > 0) || m_run || m_err);
        check("dm_we", dm_we, exp_we);
        if (exp_we) begin
            check("dm_addr", dm_addr, exp_addr);
            check("dm_wdata", dm_wdata, exp_data);
        end
        if (!rst_s) begin
            check("rst_dm_addr", dm_addr, 0);
            check("rst_dm_wdata", dm_wdata, 0);
        end
        if (dm_we === 1'b1) n_writes++;
    endtask

    task automatic idle_ticks(input int n);
        bit f;
        for (int i = 0; i < n; i++) tick(f);
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        idle_ticks(n);
        reset_n = 1'b1;
        idle_ticks(1);
    endtask

    // mode 0: continuous valid, 1: random valid, 2: valid every other cycle
    task automatic drive_stream(input logic [7:0] q_in[$], input int mode);
        logic [7:0] q[$];
        bit f;
        int cyc;
        q   = q_in;
        cyc = 0;
        while (q.size() > 0 && cyc < 4000) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = ($urandom_range(0, 1) == 1);
                default: in_valid = (cyc % 2 == 0);
            endcase
            in_data = in_valid ? q[0] : 8'($urandom);
            tick(f);
            if (f) void'(q.pop_front());
            cyc++;
        end
        in_valid = 1'b0;
        if (q.size() > 0) check("stream_timeout", q.size(), 0);
    endtask

    task automatic release_run();
        int w;
        int h;
        w = $urandom_range(0, 3);
        h = $urandom_range(1, 2);
        idle_ticks(w);
        proc_done = 1'b1;
        idle_ticks(h);
        proc_done = 1'b0;
        idle_ticks(1);
    endtask

    task automatic build_job(input int r, input int ca, input int cb, input int n_elem,
                             output logic [7:0] q[$]);
        logic [7:0] s;
        q.delete();
        q.push_back(8'(r));
        q.push_back(8'(ca));
        q.push_back(8'(cb));
        for (int i = 0; i < n_elem; i++) q.push_back(8'($urandom));
        s = '0;
        foreach (q[i]) s = s + q[i];
`ifdef MATRIX_LOADER_CHECKSUM_EN
        if (n_elem > 0) q.push_back(s);
`endif
    endtask

    initial begin
        logic [7:0] q[$];
        int r;
        int ca;
        int cb;
        bit lg;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        proc_done = 1'b0;
        idle_ticks(3);
        reset_n = 1'b1;
        idle_ticks(1);

        // proc_done outside RUN has no effect
        proc_done = 1'b1;
        idle_ticks(2);
        proc_done = 1'b0;
        idle_ticks(1);

        tbl[0] = '{2, 2, 2, 0, 1'b1, 8};
        tbl[1] = '{2, 0, 3, 0, 1'b0, 0};
        tbl[2] = '{1, 3, 1, 2, 1'b1, 6};
        tbl[3] = '{3, 4, 5, 1, 1'b1, 32};
        tbl[4] = '{17, 1, 1, 0, 1'b0, 0};
        tbl[5] = '{1, 1, 16, 0, 1'b1, 17};
        tbl[6] = '{16, 1, 1, 2, 1'b1, 17};
        tbl[7] = '{4, 2, 0, 1, 1'b0, 0};
        tbl[8] = '{16, 16, 16, 0, 1'b1, 512};
        tbl[9] = '{1, 1, 1, 1, 1'b1, 2};

        for (int i = 0; i < 10; i++) begin
            if (m_err) do_reset(2);
            n_writes = 0;
            build_job(tbl[i].r, tbl[i].ca, tbl[i].cb, tbl[i].legal ? tbl[i].total : 0, q);
            drive_stream(q, tbl[i].mode);
            if (!tbl[i].legal) begin
                in_valid = 1'b1;
                in_data  = 8'h5a;
                idle_ticks(4);
                in_valid = 1'b0;
            end
            check("row_err", err, !tbl[i].legal);
            check("row_writes", n_writes, tbl[i].legal ? 3 + tbl[i].total : 3);
            check("row_start", start_process, tbl[i].legal);
            if (tbl[i].legal) release_run();
        end

        // Reset in the middle of LOAD, then a fresh job must start at address 0
        build_job(2, 2, 2, 8, q);
        q = q[0:5];
        drive_stream(q, 0);
        do_reset(1);
        check("post_rst_busy", busy, 0);
        n_writes = 0;
        build_job(1, 2, 1, 4, q);
        drive_stream(q, 1);
        check("post_rst_writes", n_writes, 7);
        release_run();

`ifdef MATRIX_LOADER_CHECKSUM_EN
        q = '{8'd1, 8'd1, 8'd1, 8'd5, 8'd7, 8'd15};
        drive_stream(q, 0);
        check("cksum_good_start", start_process, 1);
        release_run();
        q = '{8'd1, 8'd1, 8'd1, 8'd5, 8'd7, 8'd14};
        drive_stream(q, 0);
        idle_ticks(3);
        check("cksum_bad_err", err, 1);
        check("cksum_bad_start", start_process, 0);
        do_reset(1);
`else
        q = '{8'd1, 8'd1, 8'd1, 8'd5, 8'd7};
        drive_stream(q, 0);
        check("small_job_start", start_process, 1);
        release_run();
`endif

        // Random jobs, occasionally with illegal dimensions
        for (int j = 0; j < 25; j++) begin
            if (m_err) do_reset($urandom_range(1, 2));
            r  = ($urandom_range(0, 9) == 0) ? 17 : $urandom_range(0, 5);
            ca = $urandom_range(1, 5);
            cb = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
            lg = (r >= 1 && r <= MAX_DIM && cb >= 1);
            build_job(r, ca, cb, lg ? r * ca + ca * cb : 0, q);
            drive_stream(q, $urandom_range(0, 2));
            idle_ticks(1);
            check("rand_err", err, !lg);
            if (lg) release_run();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Upstream feeder for the multicore matrix-multiplication processor (`ultimate`). The loader accepts a byte stream from the host over a valid/ready handshake. It parses a 3-byte dimension header, writes the header and the A and B operand matrices into processor data memory, and then raises `start_process`. It holds `start_process` until the processor reports `proc_done`, then re-arms for the next job.

## Interface
- `DATA_W`, 8: byte/element width; data memory word width.
- `ADDR_W`, 12: data memory address width; must satisfy 2^ADDR_W ≥ 3 + 2·MAX_DIM².
- `MAX_DIM`, 16: largest legal matrix dimension.
- `clock`  in  1: single clock; all logic rising-edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `in_data`  in  DATA_W: host byte.
- `in_valid`  in  1: host byte valid.
- `in_ready`  out  1: loader can accept a byte.
- `dm_we`  out  1: data memory write strobe.
- `dm_addr`  out  ADDR_W: data memory write address.
- `dm_wdata`  out  DATA_W: data memory write data.
- `start_process`  out  1: level start to processor.
- `proc_done`  in  1: processor completion (level or pulse).
- `busy`  out  1: high in every state except IDLE.
- `err`  out  1: sticky framing/dimension error.

## Operation
- States: IDLE, HDR, LOAD, CHK (only with macro), RUN, ERROR.
- Transfer occurs when `in_valid && in_ready`. `in_ready` = 1 in IDLE/HDR/LOAD/CHK; 0 in RUN/ERROR.
- IDLE: first transfer is `rows_a` → HDR; written to address 0.
- HDR: second byte `cols_a` (address 1), third byte `cols_b` (address 2). On the third byte, check all three dims. Any dim == 0 or > MAX_DIM → ERROR; otherwise → LOAD with `total = rows_a·cols_a + cols_a·cols_b`.
- Size arithmetic: products computed at 2·clog2(MAX_DIM+1) bits, sum one bit wider; no truncation.
- LOAD: element n (0-based) written to address 3+n, row-major. A occupies 3..3+rows_a·cols_a−1 and B follows contiguously. After element `total−1` → CHK if macro defined, else RUN.
- RUN: `start_process` = 1. Hold until `proc_done` is sampled 1, then → IDLE.
- ERROR: `err` = 1, no memory writes, no start. Exit only by reset.
- `in_valid` ignored whenever `in_ready` = 0; no bytes are buffered.
- `proc_done` outside RUN is ignored.

## Timing
- Reset values: `in_ready`=0, `dm_we`=0, `dm_addr`=0, `dm_wdata`=0, `start_process`=0, `busy`=0, `err`=0. State = IDLE. `in_ready` rises the first cycle after `reset_n` deasserts.
- Write latency: a byte accepted at edge k appears on `dm_we`/`dm_addr`/`dm_wdata` for exactly the cycle after edge k (registered). `dm_we` is low otherwise.
- Throughput: one byte per cycle sustained; back-to-back transfers are legal.
- `start_process` rises the cycle after the final accepted byte (last element or checksum). It is never concurrent with the final write cycle's predecessor.
- `proc_done` sampled at edge j in RUN: `start_process` = 0 and `in_ready` = 1 from cycle j+1.
- Reset mid-operation returns to IDLE in one cycle. Memory contents are not cleared.

## Configuration
- `MATRIX_LOADER_CHECKSUM_EN` defined: after the last element, one checksum byte is expected in CHK. It equals the mod-2^DATA_W sum of all header and element bytes.
  - Match → RUN.
  - Mismatch → ERROR; `start_process` never asserts.
  - The checksum byte is not written to memory.
- Macro undefined: CHK state absent; LOAD goes directly to RUN.

## Structure
- Shared package `matrix_pkg`: state enum, header byte offsets (0/1/2), `A_BASE`=3, `MAX_DIM` default. The processor side reads the same layout.
- One sub-module `mat_size_calc`: registers dims and produces `total` and the legality flag.

## Test plan
- 2×2·2×2: header 2,2,2 then 8 elements, `in_valid` continuous.
  - Expect writes at addresses 0..10 with the sent data.
  - `start_process` high one cycle after byte 11.
  - `proc_done` pulse → IDLE next cycle.
- Dim 0 in header (2,0,3): `err`=1 after byte 3, `in_ready`=0, no further `dm_we`, `start_process` stays 0.
- `in_valid` toggling every other cycle, dims 1,3,1: 6 elements land at addresses 3..8 in order, with no duplicate or skipped writes.
- Reset asserted mid-LOAD: next cycle all outputs are at reset values. A new header starts at address 0.
- MAX_DIM edge, dims 16,16,16: 512 elements; last element written at address 514; start follows.
- Macro on, checksum for 1,1,1 / elements 5,7: sum = 15.
  - Checksum 15 → start.
  - Checksum 14 → `err`, no start.
